// File: rtl/serial_rx_frame.sv
// serial_rx_frame
//   Receives one framed serial word on `a`: a start bit, WIDTH data bits, an
//   optional parity bit and 1-2 stop bits. The assembled word is presented on
//   out_p with a one-cycle ready strobe. Every bit is sampled at its mid-point,
//   counted in clk cycles.
//
// Ports
//   clk        rising-edge clock
//   start      asynchronous active-low reset
//   en         receiver enable; dropping it mid-frame aborts the frame
//   a          serial line, idles high
//   out_p      last complete word; holds until the next frame completes
//   ready      one-cycle pulse when a frame completes
//   busy       high whenever the receiver is not idle
//   parity_err parity mismatch of the last delivered frame
//   frame_err  a stop bit of the last delivered frame was sampled low
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for a start bit (a low while en high)
// START    | counting to the start-bit mid-point to reject line glitches
// TRANSMIT | sampling the WIDTH data bits
// PARITY   | sampling the parity bit
// STOP     | sampling the stop bits; the last one delivers the frame
module serial_rx_frame #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int MSB_FIRST    = 0,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             start,
  input  logic             en,
  input  logic             a,
  output logic [WIDTH-1:0] out_p,
  output logic             ready,
  output logic             busy,
  output logic             parity_err,
  output logic             frame_err
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  // Bit counter doubles as the data-bit index and the stop-bit counter.
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_TRANSMIT,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             ready_q, ready_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  logic             perr_pend_q, perr_pend_d;
  logic             ferr_pend_q, ferr_pend_d;
  logic             tick;
  logic [BW-1:0]    idx;

  assign tick = (cnt_q == CW'(CLKS_PER_BIT - 1));
  assign idx  = (MSB_FIRST != 0) ? (BW'(WIDTH - 1) - bit_q) : bit_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    out_d       = out_q;
    ready_d     = 1'b0;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    perr_pend_d = perr_pend_q;
    ferr_pend_d = ferr_pend_q;

    case (state_q)
      S_IDLE: begin
        if (en && !a) begin
          bit_d       = '0;
          perr_pend_d = 1'b0;
          ferr_pend_d = 1'b0;
          if (CLKS_PER_BIT == 1) begin
            state_d = S_TRANSMIT;
            cnt_d   = '0;
          end else begin
            state_d = S_START;
            cnt_d   = CW'(1);
          end
        end
      end

      S_START: begin
        if (!en) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(CLKS_PER_BIT / 2)) begin
          // Line back high at the start-bit mid-point: a glitch, not a frame.
          state_d = a ? S_IDLE : S_TRANSMIT;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_TRANSMIT, S_PARITY, S_STOP: begin
        if (!en) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          bit_d   = '0;
        end else if (!tick) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = '0;
          if (state_q == S_TRANSMIT) begin
            shreg_d[idx] = a;
            if (bit_q == BW'(WIDTH - 1)) begin
              bit_d   = '0;
              state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end else if (state_q == S_PARITY) begin
            // Every data bit is rewritten each frame, so the register holds
            // exactly this frame's word here.
            perr_pend_d = (((^shreg_q) ^ a) != (PARITY_ODD != 0));
            bit_d       = '0;
            state_d     = S_STOP;
          end else begin
            if (!a) ferr_pend_d = 1'b1;
            if (bit_q == BW'(STOP_BITS - 1)) begin
              out_d   = shreg_q;
              perr_d  = perr_pend_q;
              ferr_d  = ferr_pend_q | ~a;
              ready_d = 1'b1;
              bit_d   = '0;
              state_d = S_IDLE;
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      out_q       <= '0;
      ready_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      perr_pend_q <= 1'b0;
      ferr_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      out_q       <= out_d;
      ready_q     <= ready_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      perr_pend_q <= perr_pend_d;
      ferr_pend_q <= ferr_pend_d;
    end
  end

  assign out_p      = out_q;
  assign ready      = ready_q;
  assign busy       = (state_q != S_IDLE);
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_serial_rx_frame.sv
// Testbench for serial_rx_frame. Two receivers share clock and reset:
//   A: 8 bits, 1 clk/bit, LSB first, no parity, 1 stop bit
//   B: 8 bits, 4 clk/bit, MSB first, even parity, 2 stop bits
// Frames are described bit by bit, expanded to per-cycle line values, and the
// expected ready cycle is the last bit's mid-point sample plus one cycle.
module tb_serial_rx_frame;
  localparam int W = 8;
  localparam int CPB_A = 1, MSB_A = 0, PEN_A = 0, POD_A = 0, STOP_A = 1;
  localparam int CPB_B = 4, MSB_B = 1, PEN_B = 1, POD_B = 0, STOP_B = 2;

  logic clk = 1'b0;
  logic start, en_a, a_a, en_b, a_b;
  logic [W-1:0] out_a, out_b;
  logic rdy_a, busy_a, pe_a, fe_a;
  logic rdy_b, busy_b, pe_b, fe_b;

  always #5 clk = ~clk;

  serial_rx_frame #(.WIDTH(W), .CLKS_PER_BIT(CPB_A), .MSB_FIRST(MSB_A), .PARITY_EN(PEN_A),
                    .PARITY_ODD(POD_A), .STOP_BITS(STOP_A)) u_a (
    .clk(clk), .start(start), .en(en_a), .a(a_a), .out_p(out_a), .ready(rdy_a),
    .busy(busy_a), .parity_err(pe_a), .frame_err(fe_a));

  serial_rx_frame #(.WIDTH(W), .CLKS_PER_BIT(CPB_B), .MSB_FIRST(MSB_B), .PARITY_EN(PEN_B),
                    .PARITY_ODD(POD_B), .STOP_BITS(STOP_B)) u_b (
    .clk(clk), .start(start), .en(en_b), .a(a_b), .out_p(out_b), .ready(rdy_b),
    .busy(busy_b), .parity_err(pe_b), .frame_err(fe_b));

  typedef struct packed {
    logic [31:0]  cyc;
    logic [W-1:0] data;
    logic         pe;
    logic         fe;
  } ev_t;

  ev_t  obs_q[$];
  ev_t  exp_q[$];
  logic busy_log[$];
  bit   line_q[$];
  bit   en_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic [W-1:0] last_out_b = '0;
  logic         last_pe_b = 1'b0, last_fe_b = 1'b0;

  // Reference model: one frame as a list of bits, each held for the bit period.
  task automatic add_frame(input int which, input logic [W-1:0] data, input bit flip,
                           input bit s1, input bit s2);
    int c, msb, pen, pod, nstop, t0, nb;
    bit bits[$];
    ev_t ev;
    c     = (which != 0) ? CPB_B : CPB_A;
    msb   = (which != 0) ? MSB_B : MSB_A;
    pen   = (which != 0) ? PEN_B : PEN_A;
    pod   = (which != 0) ? POD_B : POD_A;
    nstop = (which != 0) ? STOP_B : STOP_A;
    t0    = line_q.size();
    bits.push_back(1'b0);
    for (int k = 0; k < W; k++) bits.push_back((msb != 0) ? data[W-1-k] : data[k]);
    if (pen != 0) bits.push_back((^data) ^ (pod != 0) ^ flip);
    bits.push_back(s1);
    if (nstop == 2) bits.push_back(s2);
    nb = bits.size();
    // The final stop bit is driven only up to its mid-point; the line is high
    // afterwards so a low stop bit cannot look like the next start bit.
    for (int j = 0; j < nb; j++)
      for (int r = 0; r < c; r++) begin
        line_q.push_back((j == nb - 1 && r > c / 2) ? 1'b1 : bits[j]);
        en_q.push_back(1'b1);
      end
    ev.cyc  = 32'(t0 + (nb - 1) * c + c / 2 + 1);
    ev.data = data;
    ev.pe   = (pen != 0) && flip;
    ev.fe   = !s1 || (nstop == 2 && !s2);
    exp_q.push_back(ev);
    if (which != 0) begin
      last_out_b = ev.data;
      last_pe_b  = ev.pe;
      last_fe_b  = ev.fe;
    end
  endtask

  task automatic add_idle(input int which, input int nbits);
    int c;
    c = (which != 0) ? CPB_B : CPB_A;
    for (int i = 0; i < nbits * c; i++) begin
      line_q.push_back(1'b1);
      en_q.push_back(1'b1);
    end
  endtask

  // Plays the per-cycle line/enable queue into one receiver and records
  // every ready cycle and the busy level of every cycle.
  task automatic run(input int which);
    obs_q.delete();
    busy_log.delete();
    for (int i = 0; i < line_q.size(); i++) begin
      @(posedge clk);
      #1;
      if (which == 0) begin a_a = line_q[i]; en_a = en_q[i]; end
      else begin a_b = line_q[i]; en_b = en_q[i]; end
      @(negedge clk);
      if (which == 0) begin
        busy_log.push_back(busy_a);
        if (rdy_a) obs_q.push_back({32'(i), out_a, pe_a, fe_a});
      end else begin
        busy_log.push_back(busy_b);
        if (rdy_b) obs_q.push_back({32'(i), out_b, pe_b, fe_b});
      end
    end
    line_q.delete();
    en_q.delete();
  endtask

  task automatic test_reset();
    start = 1'b0; en_a = 1'b0; en_b = 1'b0; a_a = 1'b1; a_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({out_a, rdy_a, busy_a, pe_a, fe_a} !== 12'h0) begin
      n_bad++; $display("FAIL reset_a: got %h expected 000", {out_a, rdy_a, busy_a, pe_a, fe_a});
    end
    n_vec++;
    if ({out_b, rdy_b, busy_b, pe_b, fe_b} !== 12'h0) begin
      n_bad++; $display("FAIL reset_b: got %h expected 000", {out_b, rdy_b, busy_b, pe_b, fe_b});
    end
    @(negedge clk);
    start = 1'b1; en_a = 1'b1; en_b = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy_a, busy_b, rdy_a, rdy_b} !== 4'b0) begin
      n_bad++; $display("FAIL idle_after_reset: got %b expected 0000", {busy_a, busy_b, rdy_a, rdy_b});
    end
  endtask

  task automatic test_lsb_frame();
    exp_q.delete();
    add_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1);
    add_idle(0, 4);
    run(0);
    n_vec++;
    if (obs_q.size() != 1) begin
      n_bad++; $display("FAIL lsb_ready_count: got %0d expected 1", obs_q.size());
    end else begin
      n_vec++;
      if (obs_q[0] !== exp_q[0] || obs_q[0].cyc !== 32'd10) begin
        n_bad++; $display("FAIL lsb_frame: got cyc %0d data %h pe %b fe %b expected cyc 10 data a5 pe 0 fe 0",
                          obs_q[0].cyc, obs_q[0].data, obs_q[0].pe, obs_q[0].fe);
      end
    end
  endtask

  task automatic test_msb_and_glitch();
    int g;
    exp_q.delete();
    add_frame(1, 8'h3C, 1'b0, 1'b1, 1'b1);
    add_idle(1, 2);
    g = line_q.size();
    line_q.push_back(1'b0); en_q.push_back(1'b1);
    add_idle(1, 5);
    run(1);
    n_vec++;
    if (obs_q.size() != 1) begin
      n_bad++; $display("FAIL msb_ready_count: got %0d expected 1", obs_q.size());
    end else begin
      n_vec++;
      if (obs_q[0] !== exp_q[0]) begin
        n_bad++; $display("FAIL msb_frame: got cyc %0d data %h pe %b fe %b expected cyc %0d data %h pe %b fe %b",
                          obs_q[0].cyc, obs_q[0].data, obs_q[0].pe, obs_q[0].fe,
                          exp_q[0].cyc, exp_q[0].data, exp_q[0].pe, exp_q[0].fe);
      end
    end
    n_vec++;
    if (busy_log[g+1] !== 1'b1 || busy_log[g+3] !== 1'b0) begin
      n_bad++; $display("FAIL glitch_busy: got %b%b expected 10", busy_log[g+1], busy_log[g+3]);
    end
  endtask

  task automatic test_parity();
    exp_q.delete();
    add_frame(1, 8'h07, 1'b0, 1'b1, 1'b1);
    add_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
    add_idle(1, 2);
    run(1);
    n_vec++;
    if (obs_q.size() != 2) begin
      n_bad++; $display("FAIL parity_ready_count: got %0d expected 2", obs_q.size());
    end else
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if (obs_q[i] !== exp_q[i]) begin
          n_bad++; $display("FAIL parity_frame%0d: got data %h pe %b fe %b cyc %0d expected data %h pe %b fe %b cyc %0d", i,
                            obs_q[i].data, obs_q[i].pe, obs_q[i].fe, obs_q[i].cyc,
                            exp_q[i].data, exp_q[i].pe, exp_q[i].fe, exp_q[i].cyc);
        end
      end
  endtask

  task automatic test_stop_bits();
    exp_q.delete();
    add_frame(1, 8'h55, 1'b0, 1'b1, 1'b0);
    add_idle(1, 1);
    add_frame(1, 8'h12, 1'b0, 1'b1, 1'b1);
    add_idle(1, 2);
    run(1);
    n_vec++;
    if (obs_q.size() != 2) begin
      n_bad++; $display("FAIL stop_ready_count: got %0d expected 2", obs_q.size());
    end else
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if (obs_q[i] !== exp_q[i]) begin
          n_bad++; $display("FAIL stop_frame%0d: got data %h pe %b fe %b cyc %0d expected data %h pe %b fe %b cyc %0d", i,
                            obs_q[i].data, obs_q[i].pe, obs_q[i].fe, obs_q[i].cyc,
                            exp_q[i].data, exp_q[i].pe, exp_q[i].fe, exp_q[i].cyc);
        end
      end
  endtask

  task automatic test_back_to_back();
    for (int w = 0; w < 2; w++) begin
      exp_q.delete();
      add_frame(w, 8'h81, 1'b0, 1'b1, 1'b1);
      add_frame(w, 8'h7E, 1'b0, 1'b1, 1'b1);
      add_idle(w, 3);
      run(w);
      n_vec++;
      if (obs_q.size() != 2) begin
        n_bad++; $display("FAIL b2b%0d_ready_count: got %0d expected 2", w, obs_q.size());
      end else
        for (int i = 0; i < 2; i++) begin
          n_vec++;
          if (obs_q[i] !== exp_q[i]) begin
            n_bad++; $display("FAIL b2b%0d_frame%0d: got data %h cyc %0d expected data %h cyc %0d", w, i,
                              obs_q[i].data, obs_q[i].cyc, exp_q[i].data, exp_q[i].cyc);
          end
        end
    end
  endtask

  task automatic test_random();
    for (int w = 0; w < 2; w++) begin
      exp_q.delete();
      for (int f = 0; f < 12; f++) begin
        add_idle(w, $urandom_range(0, 2));
        add_frame(w, W'($urandom), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0);
      end
      add_idle(w, 3);
      run(w);
      n_vec++;
      if (obs_q.size() != exp_q.size()) begin
        n_bad++; $display("FAIL rand%0d_ready_count: got %0d expected %0d", w, obs_q.size(), exp_q.size());
      end else
        for (int i = 0; i < exp_q.size(); i++) begin
          n_vec++;
          if (obs_q[i] !== exp_q[i]) begin
            n_bad++; $display("FAIL rand%0d_frame%0d: got data %h pe %b fe %b cyc %0d expected data %h pe %b fe %b cyc %0d",
                              w, i, obs_q[i].data, obs_q[i].pe, obs_q[i].fe, obs_q[i].cyc,
                              exp_q[i].data, exp_q[i].pe, exp_q[i].fe, exp_q[i].cyc);
          end
        end
    end
  endtask

  task automatic test_abort();
    int t0, ab;
    exp_q.delete();
    add_idle(1, 2);
    t0 = line_q.size();
    for (int i = 0; i < 5 * CPB_B; i++) begin   // start bit plus four data bits
      line_q.push_back(i < CPB_B ? 1'b0 : 1'b1);
      en_q.push_back(1'b1);
    end
    for (int i = 0; i < 40; i++) begin
      line_q.push_back(1'($urandom_range(0, 1)));
      en_q.push_back(1'b0);
    end
    add_idle(1, 4);
    run(1);
    ab = t0 + 5 * CPB_B;
    n_vec++;
    if (busy_log[ab] !== 1'b1 || busy_log[ab+1] !== 1'b0) begin
      n_bad++; $display("FAIL abort_busy: got %b%b expected 10", busy_log[ab], busy_log[ab+1]);
    end
    n_vec++;
    if (obs_q.size() != 0) begin
      n_bad++; $display("FAIL abort_no_ready: got %0d ready pulses expected 0", obs_q.size());
    end
    n_vec++;
    if ({out_b, pe_b, fe_b} !== {last_out_b, last_pe_b, last_fe_b}) begin
      n_bad++; $display("FAIL abort_hold: got %h %b %b expected %h %b %b",
                        out_b, pe_b, fe_b, last_out_b, last_pe_b, last_fe_b);
    end
  endtask

  task automatic test_reset_mid();
    exp_q.delete();
    add_idle(1, 1);
    add_frame(1, 8'hC3, 1'b0, 1'b1, 1'b1);
    add_idle(1, 2);
    run(1);
    n_vec++;
    if (obs_q.size() != 1 || out_b !== 8'hC3) begin
      n_bad++; $display("FAIL pre_reset_frame: got %0d pulses out %h expected 1 pulse out c3", obs_q.size(), out_b);
    end
    @(posedge clk);
    #1 a_b = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (busy_b !== 1'b1) begin
      n_bad++; $display("FAIL mid_frame_busy: got %b expected 1", busy_b);
    end
    #2 start = 1'b0; a_b = 1'b1;
    #1;
    n_vec++;
    if ({out_b, rdy_b, busy_b, pe_b, fe_b, out_a} !== 20'h0) begin
      n_bad++; $display("FAIL async_reset: got %h expected 00000", {out_b, rdy_b, busy_b, pe_b, fe_b, out_a});
    end
    #1 start = 1'b1;
    exp_q.delete();
    add_idle(1, 2);
    add_frame(1, 8'h5A, 1'b0, 1'b1, 1'b1);
    add_idle(1, 2);
    run(1);
    n_vec++;
    if (obs_q.size() != 1) begin
      n_bad++; $display("FAIL post_reset_ready_count: got %0d expected 1", obs_q.size());
    end else begin
      n_vec++;
      if (obs_q[0] !== exp_q[0]) begin
        n_bad++; $display("FAIL post_reset_frame: got data %h cyc %0d expected data %h cyc %0d",
                          obs_q[0].data, obs_q[0].cyc, exp_q[0].data, exp_q[0].cyc);
      end
    end
  endtask

  initial begin
    start = 1'b0; en_a = 1'b0; en_b = 1'b0; a_a = 1'b1; a_b = 1'b1;
    test_reset();
    test_lsb_frame();
    test_msb_and_glitch();
    test_parity();
    test_stop_bits();
    test_back_to_back();
    test_random();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
